issue_stage: RTL and testbench
==============================

ISSUE_STAGE -- requirements
Module: issue_stage

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 dec_valid  in  1 / dec_ready  out  1  decode handshake; an instruction issues in a cycle with dec_valid=1 and dec_ready=1.
REQ-004 dec_rs1, dec_rs2, dec_rd  in  5 each  source and destination register addresses.
REQ-005 dec_we  in  1  / dec_use_imm  in  1  / dec_imm  in  32  write enable; operand-B select; immediate.
REQ-006 dec_alu_fn  in  4 / dec_fn  in  3 / dec_pc  in  32  ALU control, writeback-select code, instruction PC.
REQ-007 wb_we  in  1 / wb_rd  in  5 / wb_data  in  32  writeback port, driven by the execute stage's we6/rd6/wb_data6.
REQ-008 flush  in  1  branch/jump taken; squashes the instruction in the output register.
REQ-009 op_a, op_b  out  32 / rd4  out  5 / we4  out  1 / alu_fn4  out  4 / fn4  out  3 / pc4  out  32  registered issue outputs to the execute stage.

Function
REQ-010 Internal register file of 32x32 bits; x0 reads 0; writes to x0 are ignored.
REQ-011 Register-file write occurs at the clock edge ending any cycle with wb_we=1 and wb_rd!=0.
REQ-012 Scoreboard holds one 2-bit pending counter per register; a counter that is nonzero decrements by 1 each cycle.
REQ-013 On issue with dec_we=1 and dec_rd!=0, pending[dec_rd] is loaded with 3, overriding both its current value and that cycle's decrement.
REQ-014 Hazard for a source: pending[rs]>1 with ISSUE_BYPASS_EN defined, or pending[rs]!=0 without it; rs2 is checked only when dec_use_imm=0; x0 never hazards.
REQ-015 dec_ready = !hazard and !rst (combinational); it does not depend on dec_valid.
REQ-016 Operand read: if wb_we=1, wb_rd==rs and rs!=0, the value is wb_data (bypass, ISSUE_BYPASS_EN only); otherwise the value comes from the register-file array.
REQ-017 op_b takes dec_imm when dec_use_imm=1, otherwise the rs2 value.
REQ-018 Issue latency: the outputs hold the issued instruction in the cycle after the handshake, for exactly one cycle.
REQ-019 A cycle with no issue (stall, dec_valid=0, or flush) loads a bubble: all outputs zero.
REQ-020 flush=1 forces a bubble load regardless of handshake; an instruction presented that cycle is not issued, and its scoreboard entry is not loaded.
REQ-021 flush does not clear pending counters of already-issued instructions; they count down normally.
REQ-022 Issue with dec_rd equal to one of its own sources reads the pre-issue value.

Reset
REQ-023 With rst=1: all outputs 0, all pending counters 0, all register-file entries 0, and dec_ready=0, taking effect immediately without waiting for a clock edge.
REQ-024 Reset asserted mid-stall or mid-countdown discards all in-flight scoreboard state; the first cycle after deassertion is able to issue.

Configuration
REQ-025 Macro ISSUE_BYPASS_EN: when defined, the wb_data bypass is present and a dependent instruction issues 3 cycles after its producer (2 stall cycles).
REQ-026 When ISSUE_BYPASS_EN is undefined, there is no bypass mux; a dependent instruction issues 4 cycles after its producer (3 stall cycles), and all reads come from the register-file array.

Verification
REQ-027 Reset then write x5=0x12345678 via the wb port -> issuing rs1=5 gives op_a=0x12345678 one cycle later; rs1=0 gives op_a=0.
REQ-028 Issue rd=3 at cycle t, then rs1=3 at t+1 -> dec_ready=0 at t+1 and t+2; issues at t+3 with op_a=wb_data (bypass build); no-bypass build stalls through t+3 and issues at t+4.
REQ-029 dec_use_imm=1, dec_imm=0xFFFFF800, rs2 pending -> no stall, op_b=0xFFFFF800.
REQ-030 flush=1 in the handshake cycle of an instruction with rd=7 -> next-cycle outputs all 0, and a following rs1=7 issues without stall.
REQ-031 wb_we=1 with wb_rd=0 and wb_data=0xDEADBEEF -> a later read of x0 returns 0.
REQ-032 rst asserted while pending[4]=2, then deasserted -> rs1=4 issues immediately with op_a=0.

Source files
------------

// File: rtl/issue_stage.sv
// Issue stage: register file, 2-bit-per-register scoreboard and registered issue outputs.
// Optional macro ISSUE_BYPASS_EN adds the writeback-to-operand bypass and shortens the stall by one cycle.
module issue_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        dec_valid,
    output logic        dec_ready,
    input  logic [4:0]  dec_rs1,
    input  logic [4:0]  dec_rs2,
    input  logic [4:0]  dec_rd,
    input  logic        dec_we,
    input  logic        dec_use_imm,
    input  logic [31:0] dec_imm,
    input  logic [3:0]  dec_alu_fn,
    input  logic [2:0]  dec_fn,
    input  logic [31:0] dec_pc,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        flush,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic [4:0]  rd4,
    output logic        we4,
    output logic [3:0]  alu_fn4,
    output logic [2:0]  fn4,
    output logic [31:0] pc4
);

    logic [31:0] rf_q      [32];
    logic [31:0] rf_d      [32];
    logic [1:0]  pending_q [32];
    logic [1:0]  pending_d [32];

    logic [31:0] op_a_q, op_a_d, op_b_q, op_b_d, pc4_q, pc4_d;
    logic [4:0]  rd4_q, rd4_d;
    logic        we4_q, we4_d;
    logic [3:0]  alu_fn4_q, alu_fn4_d;
    logic [2:0]  fn4_q, fn4_d;

    logic        haz_rs1, haz_rs2, issue;
    logic [31:0] rs1_val, rs2_val;

    function automatic logic busy(input logic [1:0] cnt);
`ifdef ISSUE_BYPASS_EN
        // The last countdown cycle is covered by the writeback bypass.
        return cnt > 2'd1;
`else
        return cnt != 2'd0;
`endif
    endfunction

    always_comb begin
        haz_rs1   = (dec_rs1 != 5'd0) && busy(pending_q[dec_rs1]);
        haz_rs2   = !dec_use_imm && (dec_rs2 != 5'd0) && busy(pending_q[dec_rs2]);
        dec_ready = !(haz_rs1 || haz_rs2) && !rst;
        issue     = dec_valid && dec_ready && !flush;
    end

    always_comb begin
        rs1_val = (dec_rs1 == 5'd0) ? 32'd0 : rf_q[dec_rs1];
        rs2_val = (dec_rs2 == 5'd0) ? 32'd0 : rf_q[dec_rs2];
`ifdef ISSUE_BYPASS_EN
        if (wb_we && (wb_rd == dec_rs1) && (dec_rs1 != 5'd0)) rs1_val = wb_data;
        if (wb_we && (wb_rd == dec_rs2) && (dec_rs2 != 5'd0)) rs2_val = wb_data;
`endif
    end

    always_comb begin
        for (int i = 0; i < 32; i++) begin
            rf_d[i]      = rf_q[i];
            pending_d[i] = (pending_q[i] != 2'd0) ? pending_q[i] - 2'd1 : 2'd0;
        end
        if (wb_we && (wb_rd != 5'd0)) rf_d[wb_rd] = wb_data;
        if (issue && dec_we && (dec_rd != 5'd0)) pending_d[dec_rd] = 2'd3;
    end

    always_comb begin
        op_a_d    = 32'd0;
        op_b_d    = 32'd0;
        rd4_d     = 5'd0;
        we4_d     = 1'b0;
        alu_fn4_d = 4'd0;
        fn4_d     = 3'd0;
        pc4_d     = 32'd0;
        if (issue) begin
            op_a_d    = rs1_val;
            op_b_d    = dec_use_imm ? dec_imm : rs2_val;
            rd4_d     = dec_rd;
            we4_d     = dec_we;
            alu_fn4_d = dec_alu_fn;
            fn4_d     = dec_fn;
            pc4_d     = dec_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i]      <= 32'd0;
                pending_q[i] <= 2'd0;
            end
            op_a_q    <= 32'd0;
            op_b_q    <= 32'd0;
            rd4_q     <= 5'd0;
            we4_q     <= 1'b0;
            alu_fn4_q <= 4'd0;
            fn4_q     <= 3'd0;
            pc4_q     <= 32'd0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i]      <= rf_d[i];
                pending_q[i] <= pending_d[i];
            end
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            rd4_q     <= rd4_d;
            we4_q     <= we4_d;
            alu_fn4_q <= alu_fn4_d;
            fn4_q     <= fn4_d;
            pc4_q     <= pc4_d;
        end
    end

    assign op_a    = op_a_q;
    assign op_b    = op_b_q;
    assign rd4     = rd4_q;
    assign we4     = we4_q;
    assign alu_fn4 = alu_fn4_q;
    assign fn4     = fn4_q;
    assign pc4     = pc4_q;

endmodule

// File: tb/tb_issue_stage.sv
// Bench for issue_stage: directed scenarios then random traffic against a cycle-stamp reference model.
module tb_issue_stage;

`ifdef ISSUE_BYPASS_EN
    localparam int Dist = 3;
`else
    localparam int Dist = 4;
`endif

    logic        clk, rst, dec_valid, dec_ready, dec_we, dec_use_imm, wb_we, flush, we4;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd, wb_rd, rd4;
    logic [31:0] dec_imm, dec_pc, wb_data, op_a, op_b, pc4;
    logic [3:0]  dec_alu_fn, alu_fn4;
    logic [2:0]  dec_fn, fn4;

    issue_stage dut (
        .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd), .dec_we(dec_we),
        .dec_use_imm(dec_use_imm), .dec_imm(dec_imm), .dec_alu_fn(dec_alu_fn),
        .dec_fn(dec_fn), .dec_pc(dec_pc), .wb_we(wb_we), .wb_rd(wb_rd),
        .wb_data(wb_data), .flush(flush), .op_a(op_a), .op_b(op_b), .rd4(rd4),
        .we4(we4), .alu_fn4(alu_fn4), .fn4(fn4), .pc4(pc4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: architectural register values and the cycle each register was last claimed.
    logic [31:0] m_rf   [32];
    int          m_last [32];
    int          cyc = 0;
    logic [31:0] e_op_a, e_op_b, e_pc4;
    logic [4:0]  e_rd4;
    logic        e_we4;
    logic [3:0]  e_alu;
    logic [2:0]  e_fn;
    logic        last_ready;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_rf[i]   = 32'd0;
            m_last[i] = -100;
        end
        {e_op_a, e_op_b, e_pc4, e_rd4, e_we4, e_alu, e_fn} = '0;
    endtask

    function automatic logic m_busy(input logic [4:0] r);
        return (r != 5'd0) && ((cyc - m_last[r]) < Dist);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
`ifdef ISSUE_BYPASS_EN
        if (wb_we && wb_rd == r) return wb_data;
`endif
        return m_rf[r];
    endfunction

    task automatic chk_outs(input string where);
        chk({where, ".op_a"}, op_a, e_op_a);
        chk({where, ".op_b"}, op_b, e_op_b);
        chk({where, ".rd4"}, {27'd0, rd4}, {27'd0, e_rd4});
        chk({where, ".we4"}, {31'd0, we4}, {31'd0, e_we4});
        chk({where, ".alu_fn4"}, {28'd0, alu_fn4}, {28'd0, e_alu});
        chk({where, ".fn4"}, {29'd0, fn4}, {29'd0, e_fn});
        chk({where, ".pc4"}, pc4, e_pc4);
    endtask

    // One clock cycle with the currently driven inputs.
    task automatic step();
        logic        exp_ready, iss;
        logic [31:0] n_a, n_b, n_pc;
        logic [4:0]  n_rd;
        logic        n_we;
        logic [3:0]  n_alu;
        logic [2:0]  n_fn;
        #1;
        if (rst) model_reset();
        chk_outs("mid");
        exp_ready = !(m_busy(dec_rs1) || (!dec_use_imm && m_busy(dec_rs2))) && !rst;
        chk("dec_ready", {31'd0, dec_ready}, {31'd0, exp_ready});
        last_ready = dec_ready;
        iss = dec_valid && exp_ready && !flush;
        {n_a, n_b, n_pc, n_rd, n_we, n_alu, n_fn} = '0;
        if (iss) begin
            n_a   = m_read(dec_rs1);
            n_b   = dec_use_imm ? dec_imm : m_read(dec_rs2);
            n_rd  = dec_rd;
            n_we  = dec_we;
            n_alu = dec_alu_fn;
            n_fn  = dec_fn;
            n_pc  = dec_pc;
        end
        @(posedge clk);
        if (!rst) begin
            if (iss && dec_we && dec_rd != 5'd0) m_last[dec_rd] = cyc;
            if (wb_we && wb_rd != 5'd0) m_rf[wb_rd] = wb_data;
            {e_op_a, e_op_b, e_pc4, e_rd4, e_we4, e_alu, e_fn} =
                {n_a, n_b, n_pc, n_rd, n_we, n_alu, n_fn};
        end else begin
            model_reset();
        end
        cyc++;
        #1;
        chk_outs("post");
    endtask

    task automatic clear_in();
        {dec_valid, dec_we, dec_use_imm, wb_we, flush} = '0;
        {dec_rs1, dec_rs2, dec_rd, wb_rd} = '0;
        {dec_imm, dec_pc, wb_data} = '0;
        dec_alu_fn = 4'd0;
        dec_fn     = 3'd0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int stalls;
        model_reset();
        clear_in();
        rst = 1'b1;
        #2;
        chk("reset.dec_ready", {31'd0, dec_ready}, 32'd0);
        chk("reset.op_a", op_a, 32'd0);
        step();
        step();
        rst = 1'b0;
        step();

        // x5 write through the writeback port, then read x5 and x0
        wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234_5678;
        step();
        clear_in();
        dec_valid = 1'b1; dec_rs1 = 5'd5; dec_use_imm = 1'b1; dec_pc = 32'h40;
        step();
        chk("x5_read", op_a, 32'h1234_5678);
        dec_rs1 = 5'd0;
        step();
        chk("x0_read", op_a, 32'd0);

        // RAW dependence on x3: stall count and forwarded/written value
        clear_in();
        dec_valid = 1'b1; dec_we = 1'b1; dec_rd = 5'd3; dec_use_imm = 1'b1;
        step();
        clear_in();
        dec_valid = 1'b1; dec_rs1 = 5'd3; dec_use_imm = 1'b1; dec_alu_fn = 4'd2;
        stalls = 0;
        for (int i = 0; i < 6; i++) begin
            wb_we = (i == 2); wb_rd = 5'd3; wb_data = 32'hCAFE_0003;
            step();
            if (last_ready) break;
            stalls++;
        end
        chk("raw_stalls", stalls, Dist - 1);
        chk("raw_op_a", op_a, 32'hCAFE_0003);

        // Immediate operand ignores a pending rs2
        clear_in();
        dec_valid = 1'b1; dec_we = 1'b1; dec_rd = 5'd9; dec_use_imm = 1'b1;
        step();
        clear_in();
        dec_valid = 1'b1; dec_use_imm = 1'b1; dec_rs2 = 5'd9; dec_imm = 32'hFFFF_F800;
        step();
        chk("imm_ready", {31'd0, last_ready}, 32'd1);
        chk("imm_op_b", op_b, 32'hFFFF_F800);

        // Flush squashes the issue and its scoreboard claim
        clear_in();
        dec_valid = 1'b1; dec_we = 1'b1; dec_rd = 5'd7; dec_pc = 32'h100; flush = 1'b1;
        dec_fn = 3'd5;
        step();
        chk("flush_pc4", pc4, 32'd0);
        chk("flush_rd4", {27'd0, rd4}, 32'd0);
        clear_in();
        dec_valid = 1'b1; dec_rs1 = 5'd7; dec_use_imm = 1'b1;
        step();
        chk("flush_no_stall", {31'd0, last_ready}, 32'd1);

        // Writes to x0 are dropped
        clear_in();
        wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEAD_BEEF;
        step();
        clear_in();
        dec_valid = 1'b1;
        step();
        chk("x0_write_a", op_a, 32'd0);
        chk("x0_write_b", op_b, 32'd0);

        // Reset mid-countdown discards scoreboard state
        clear_in();
        wb_we = 1'b1; wb_rd = 5'd4; wb_data = 32'h4444_4444;
        step();
        clear_in();
        dec_valid = 1'b1; dec_we = 1'b1; dec_rd = 5'd4; dec_use_imm = 1'b1;
        step();
        clear_in();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        dec_valid = 1'b1; dec_rs1 = 5'd4; dec_use_imm = 1'b1;
        step();
        chk("rst_ready", {31'd0, last_ready}, 32'd1);
        chk("rst_op_a", op_a, 32'd0);

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            dec_valid   = ($urandom_range(0, 3) != 0);
            dec_rs1     = 5'($urandom_range(0, 7));
            dec_rs2     = 5'($urandom_range(0, 7));
            dec_rd      = 5'($urandom_range(0, 7));
            dec_we      = 1'($urandom);
            dec_use_imm = 1'($urandom);
            dec_imm     = $urandom;
            dec_alu_fn  = 4'($urandom);
            dec_fn      = 3'($urandom);
            dec_pc      = $urandom;
            wb_we       = 1'($urandom);
            wb_rd       = 5'($urandom_range(0, 7));
            wb_data     = $urandom;
            flush       = ($urandom_range(0, 7) == 0);
            rst         = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;
        clear_in();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
